// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Zero-latency accept: gnt, fifo_winc and fifo_wdata all belong to the same cycle.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*WIDTH-1:0]    din,
  input  logic                     fifo_full,
  output logic [NREQ-1:0]          gnt,
  output logic                     fifo_winc,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_n;
  logic [OW-1:0]   owner_n, prio_last, prio_n, hit_idx, idx;
  logic [CW-1:0]   cnt, cnt_n;
  logic            hit, accept;
  logic [WIDTH-1:0] din_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign din_arr[g] = din[g*WIDTH +: WIDTH];
  end

  // First requester after the previous owner, wrapping around.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = OW'((int'(prio_last) + i) % NREQ);
      if (!hit && req[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign accept     = (state == BURST) && req[owner] && !fifo_full && !rst;
  assign fifo_winc  = accept;
  assign fifo_wdata = din_arr[owner];
  assign busy       = (state == BURST);

  always_comb begin
    gnt = '0;
    if (accept) gnt[owner] = 1'b1;
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    prio_n  = prio_last;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          owner_n = hit_idx;
          cnt_n   = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          state_n = IDLE;
          prio_n  = owner;
        end else if (accept) begin
          cnt_n = cnt + CW'(1);
          if (last[owner] || cnt == CW'(MAX_BURST - 1)) begin
            state_n = IDLE;
            prio_n  = owner;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      prio_last <= OW'(NREQ - 1);
      cnt       <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      prio_last <= prio_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 8, NREQ = 4, MAX_BURST = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ-1:0]         last = '0;
  logic [NREQ*WIDTH-1:0]   din = '0;
  logic                    fifo_full = 1'b0;
  logic [NREQ-1:0]         gnt;
  logic                    fifo_winc;
  logic [WIDTH-1:0]        fifo_wdata;
  logic                    busy;
  logic [1:0]              owner;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .din(din), .fifo_full(fifo_full),
    .gnt(gnt), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0, cyc = 0, c0 = 0, n = 0, first_round = 0;
  logic [8:0] rq [NREQ][$];
  logic [9:0] exp_q [$];
  int         wr_cyc [$];
  logic [NREQ-1:0] gnt_s;
  logic       winc_s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_wr(input int r, input logic [7:0] d);
    exp_q.push_back({r[1:0], d});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0) begin
        req[i] = 1'b1;
        din[i*WIDTH +: WIDTH] = rq[i][0][7:0];
        last[i] = rq[i][0][8];
      end else begin
        req[i]  = 1'b0;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    gnt_s  = gnt;
    winc_s = fifo_winc;
    if (fifo_winc) begin
      check_eq("no_write_when_full", 32'(fifo_full), 32'd0);
      check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wdata", 32'(fifo_wdata), 32'(e[7:0]));
        check_eq("gnt_onehot", 32'(gnt), 32'(4'b0001 << e[9:8]));
        check_eq("owner", 32'(owner), 32'(e[9:8]));
        wr_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (gnt_s[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    drive();
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all four requesting; each gets one single-word burst afterwards.
    for (int r = 0; r < NREQ; r++) begin
      load(r, 8'(8'h10 + r), 1'b1);
      expect_wr(r, 8'(8'h10 + r));
    end
    drive();
    rst = 1'b1;
    step();
    check_eq("rst_gnt_c1", 32'(gnt_s), 32'd0);
    check_eq("rst_winc_c1", 32'(winc_s), 32'd0);
    step();
    check_eq("rst_gnt_c2", 32'(gnt_s), 32'd0);
    check_eq("rst_winc_c2", 32'(winc_s), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    drain();

    // Single requester, three words ending on last.
    wr_cyc.delete();
    load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1);
    expect_wr(1, 8'hA1); expect_wr(1, 8'hA2); expect_wr(1, 8'hA3);
    drive();
    c0 = cyc;
    drain();
    check_eq("single_busy_fall", 32'(busy), 32'd0);
    check_eq("single_nwr", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      check_eq("single_latency", 32'(wr_cyc[0] - c0), 32'd1);
      check_eq("single_back2back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    end

    // Round robin: everyone holds req for two full rounds.
    do_reset();
    wr_cyc.delete();
    for (int r = 0; r < NREQ; r++)
      for (int w = 0; w < 2*MAX_BURST; w++)
        load(r, 8'(r*16 + w), 1'b0);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREQ; r++)
        for (int w = 0; w < MAX_BURST; w++)
          expect_wr(r, 8'(r*16 + k*MAX_BURST + w));
    drive();
    c0 = cyc;
    drain();
    check_eq("rr_nwr", 32'(wr_cyc.size()), 32'd32);
    if (wr_cyc.size() == 32) begin
      check_eq("rr_latency", 32'(wr_cyc[0] - c0), 32'd1);
      check_eq("rr_span", 32'(wr_cyc[31] - wr_cyc[0]), 32'd38);
      first_round = 0;
      foreach (wr_cyc[i]) if (wr_cyc[i] < c0 + 20) first_round++;
      check_eq("rr_writes_per_round", 32'(first_round), 32'd16);
    end

    // Backpressure: FIFO full for three cycles after the second word.
    do_reset();
    wr_cyc.delete();
    for (int w = 0; w < 4; w++) begin
      load(0, 8'(8'h51 + w), 1'b0);
      expect_wr(0, 8'(8'h51 + w));
    end
    drive();
    n = 0;
    while (wr_cyc.size() < 2 && n < 50) begin step(); n++; end
    check_eq("bp_reach_2nd", 32'(wr_cyc.size()), 32'd2);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq("bp_stall_gnt", 32'(gnt_s), 32'd0);
      check_eq("bp_stall_winc", 32'(winc_s), 32'd0);
      check_eq("bp_stall_busy", 32'(busy), 32'd1);
    end
    fifo_full = 1'b0;
    drain();
    check_eq("bp_nwr", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4)
      check_eq("bp_resume_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);

    // Abandon: owner 2 runs dry after two words, 3 takes over, 2 comes back on wrap.
    do_reset();
    wr_cyc.delete();
    load(2, 8'h21, 1'b0); load(2, 8'h22, 1'b0);
    load(3, 8'h31, 1'b0); load(3, 8'h32, 1'b1);
    expect_wr(2, 8'h21); expect_wr(2, 8'h22);
    expect_wr(3, 8'h31); expect_wr(3, 8'h32);
    expect_wr(2, 8'h23);
    drive();
    n = 0;
    while (!(busy && owner == 2'd3) && n < 50) begin step(); n++; end
    check_eq("ab_owner3", 32'(owner), 32'd3);
    load(2, 8'h23, 1'b1);
    drive();
    drain();
    check_eq("ab_nwr", 32'(wr_cyc.size()), 32'd5);
    if (wr_cyc.size() == 5) begin
      check_eq("ab_release_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd3);
      check_eq("ab_wrap_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);
    end

    // Reset in the cycle owner 1 offers its second word.
    do_reset();
    wr_cyc.delete();
    for (int w = 0; w < 4; w++) load(1, 8'(8'h41 + w), 1'b0);
    expect_wr(1, 8'h41);
    drive();
    n = 0;
    while (wr_cyc.size() < 1 && n < 50) begin step(); n++; end
    rst = 1'b1;
    step();
    check_eq("mrst_gnt", 32'(gnt_s), 32'd0);
    check_eq("mrst_winc", 32'(winc_s), 32'd0);
    rst = 1'b0;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_owner", 32'(owner), 32'd0);
    load(0, 8'h05, 1'b1);
    expect_wr(0, 8'h05);
    expect_wr(1, 8'h42); expect_wr(1, 8'h43); expect_wr(1, 8'h44);
    drive();
    drain();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
